// File: rtl/emu_host_sequencer.sv
// emu_host_sequencer: host-side transactor for an 8-bit co-emulation wrapper port.
// Takes one stimulus frame from a host byte stream and writes it into the wrapper.
// It then pulses load_emu, applies one gated clk_dut period and pulses get_emu.
// Finally it reads the DUT output bytes back and streams them to the host.
//
// Ports:
//   clk_emu, rst_emu            emulation clock, synchronous active-high reset
//   rx_data/rx_valid/rx_ready   host stimulus byte stream (ready/valid)
//   tx_data/tx_valid/tx_ready   response byte stream to host (ready/valid)
//   Din_emu, Addr_emu           wrapper write data / byte address
//   load_emu, get_emu           one-cycle wrapper transfer / capture pulses
//   Dout_emu                    wrapper readback, registered one cycle after Addr_emu
//   clk_dut                     controlled DUT clock
//   busy                        high whenever not accepting stimulus
//
// Optional build macro EMU_FRAME_CNT_EN: appends an 8-bit frame counter byte to every
// response frame.
module emu_host_sequencer #(
  parameter int unsigned NUM_STIM = 3,
  parameter int unsigned NUM_OUT  = 2,
  parameter int unsigned CLK_HALF = 1
) (
  input  logic       clk_emu,
  input  logic       rst_emu,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] Din_emu,
  output logic [2:0] Addr_emu,
  output logic       load_emu,
  output logic       get_emu,
  input  logic [7:0] Dout_emu,
  output logic       clk_dut,
  output logic       busy
);

`ifdef EMU_FRAME_CNT_EN
  typedef enum logic [3:0] {
    StRx, StSettle, StLoad, StClkH, StClkL, StGet, StRaddr, StRcap, StTx, StTrail
  } state_e;
`else
  typedef enum logic [3:0] {
    StRx, StSettle, StLoad, StClkH, StClkL, StGet, StRaddr, StRcap, StTx
  } state_e;
`endif

  localparam logic [2:0] KLast    = 3'(NUM_STIM - 1);
  localparam logic [2:0] JLast    = 3'(NUM_OUT - 1);
  localparam logic [7:0] HalfLast = 8'(CLK_HALF - 1);

  state_e     state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [2:0] j_q, j_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] shadow_q [NUM_STIM];
  logic [7:0] shadow_d [NUM_STIM];
`ifdef EMU_FRAME_CNT_EN
  logic [7:0] fcnt_q, fcnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    j_d        = j_q;
    addr_d     = addr_q;
    hcnt_d     = hcnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    shadow_d   = shadow_q;
`ifdef EMU_FRAME_CNT_EN
    fcnt_d     = fcnt_q;
`endif
    rx_ready   = 1'b0;
    load_emu   = 1'b0;
    get_emu    = 1'b0;
    clk_dut    = 1'b0;
    busy       = 1'b1;

    unique case (state_q)
      StRx: begin
        rx_ready = 1'b1;
        busy     = 1'b0;
        if (rx_valid) begin
          for (int i = 0; i < int'(NUM_STIM); i++) begin
            if (k_q == 3'(i)) shadow_d[i] = rx_data;
          end
          // Pointing Addr_emu at the new byte lets the wrapper write it next edge.
          addr_d = k_q;
          if (k_q == KLast) begin
            k_d     = 3'd0;
            state_d = StSettle;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      StSettle: state_d = StLoad;
      StLoad: begin
        load_emu = 1'b1;
        hcnt_d   = HalfLast;
        state_d  = StClkH;
      end
      StClkH: begin
        clk_dut = 1'b1;
        if (hcnt_q == 8'd0) begin
          hcnt_d  = HalfLast;
          state_d = StClkL;
        end else begin
          hcnt_d = hcnt_q - 8'd1;
        end
      end
      StClkL: begin
        if (hcnt_q == 8'd0) begin
          state_d = StGet;
        end else begin
          hcnt_d = hcnt_q - 8'd1;
        end
      end
      StGet: begin
        get_emu = 1'b1;
        j_d     = 3'd0;
        addr_d  = 3'd0;
        state_d = StRaddr;
      end
      // Addr_emu already holds j here; the wrapper registers out[j] at the end of it.
      StRaddr: state_d = StRcap;
      StRcap: begin
        tx_data_d  = Dout_emu;
        tx_valid_d = 1'b1;
        state_d    = StTx;
      end
      StTx: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (j_q == JLast) begin
`ifdef EMU_FRAME_CNT_EN
            tx_data_d  = fcnt_q;
            tx_valid_d = 1'b1;
            state_d    = StTrail;
`else
            state_d = StRx;
`endif
          end else begin
            j_d     = j_q + 3'd1;
            addr_d  = j_q + 3'd1;
            state_d = StRaddr;
          end
        end
      end
`ifdef EMU_FRAME_CNT_EN
      StTrail: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          fcnt_d     = fcnt_q + 8'd1;
          state_d    = StRx;
        end
      end
`endif
      default: state_d = StRx;
    endcase
  end

  // Din_emu always mirrors the shadow copy so idle wrapper writes are harmless.
  always_comb begin
    Din_emu = 8'h00;
    for (int i = 0; i < int'(NUM_STIM); i++) begin
      if (addr_q == 3'(i)) Din_emu = shadow_q[i];
    end
  end

  always_ff @(posedge clk_emu) begin
    if (rst_emu) begin
      state_q    <= StRx;
      k_q        <= 3'd0;
      j_q        <= 3'd0;
      addr_q     <= 3'd0;
      hcnt_q     <= 8'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      for (int i = 0; i < int'(NUM_STIM); i++) shadow_q[i] <= 8'h00;
`ifdef EMU_FRAME_CNT_EN
      fcnt_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      j_q        <= j_d;
      addr_q     <= addr_d;
      hcnt_q     <= hcnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      shadow_q   <= shadow_d;
`ifdef EMU_FRAME_CNT_EN
      fcnt_q     <= fcnt_d;
`endif
    end
  end

  assign Addr_emu = addr_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_emu_host_sequencer.sv
// Bench for emu_host_sequencer. Three instances share one clock:
// instance 0 uses CLK_HALF=1, instance 1 uses CLK_HALF=4 and instance 2 uses CLK_HALF=3.
// Each instance gets its own wrapper model plus a cycle-stamp monitor.
module tb_emu_host_sequencer;

  typedef struct packed {
    int          cyc;
    int          load_cnt;
    int          get_cnt;
    int          rise_cnt;
    int          hs_cnt;
    int          ovl_cnt;
    int          acc_cyc;
    int          load_cyc;
    int          rise_cyc;
    int          fall_cyc;
    int          get_cyc;
    int          tv_prev;
    int          tv_last;
    logic [23:0] stim;
    logic [23:0] dut_in;
  } mon_t;

`ifdef EMU_FRAME_CNT_EN
  localparam int NResp = 3;
`else
  localparam int NResp = 2;
`endif

  logic       clk;
  logic       rst      [3];
  logic [7:0] rx_data  [3];
  logic       rx_valid [3];
  logic       rx_ready [3];
  logic [7:0] tx_data  [3];
  logic       tx_valid [3];
  logic       tx_ready [3];
  logic [7:0] Din_emu  [3];
  logic [2:0] Addr_emu [3];
  logic       load_emu [3];
  logic       get_emu  [3];
  logic       clk_dut  [3];
  logic       busy     [3];
  mon_t       mon      [3];

  int checks   = 0;
  int failures = 0;
  int fexp [3] = '{0, 0, 0};

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned Ch = (g == 0) ? 1 : (g == 1) ? 4 : 3;
    logic [7:0] out0 = 8'h00;
    logic [7:0] out1 = 8'h00;
    logic [7:0] dout = 8'h00;
    logic       pclk = 1'b0;
    logic       ptv  = 1'b0;
    mon_t       m    = '0;

    emu_host_sequencer #(
      .NUM_STIM(3),
      .NUM_OUT (2),
      .CLK_HALF(Ch)
    ) u_dut (
      .clk_emu (clk),
      .rst_emu (rst[g]),
      .rx_data (rx_data[g]),
      .rx_valid(rx_valid[g]),
      .rx_ready(rx_ready[g]),
      .tx_data (tx_data[g]),
      .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready[g]),
      .Din_emu (Din_emu[g]),
      .Addr_emu(Addr_emu[g]),
      .load_emu(load_emu[g]),
      .get_emu (get_emu[g]),
      .Dout_emu(dout),
      .clk_dut (clk_dut[g]),
      .busy    (busy[g])
    );

    // Wrapper model plus monitor.
    always @(posedge clk) begin
      m.cyc <= m.cyc + 1;
      if (!load_emu[g] && !get_emu[g]) begin
        if (Addr_emu[g] < 3'd3) m.stim[8*int'(Addr_emu[g]) +: 8] <= Din_emu[g];
        dout <= (Addr_emu[g] == 3'd0) ? out0 : (Addr_emu[g] == 3'd1) ? out1 : 8'h00;
      end
      if (load_emu[g]) m.dut_in <= m.stim;
      if (get_emu[g]) begin
        out0 <= 8'hA7;
        out1 <= 8'h01;
      end
      if (rx_valid[g] && rx_ready[g]) m.acc_cyc <= m.cyc;
      if (load_emu[g]) begin
        m.load_cnt <= m.load_cnt + 1;
        m.load_cyc <= m.cyc;
      end
      if (get_emu[g]) begin
        m.get_cnt <= m.get_cnt + 1;
        m.get_cyc <= m.cyc;
      end
      if (clk_dut[g] && !pclk) begin
        m.rise_cnt <= m.rise_cnt + 1;
        m.rise_cyc <= m.cyc;
      end
      if (!clk_dut[g] && pclk) m.fall_cyc <= m.cyc;
      pclk <= clk_dut[g];
      if (tx_valid[g] && !ptv) begin
        m.tv_prev <= m.tv_last;
        m.tv_last <= m.cyc;
      end
      ptv <= tx_valid[g];
      if (tx_valid[g] && tx_ready[g]) m.hs_cnt <= m.hs_cnt + 1;
      if ((32'(load_emu[g]) + 32'(get_emu[g]) + 32'(clk_dut[g])) > 32'd1)
        m.ovl_cnt <= m.ovl_cnt + 1;
    end

    assign mon[g] = m;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bytes are packed little-end first: bytes[7:0] is sent first. Called at a negedge.
  task automatic send_bytes(input int i, input logic [23:0] bytes, input int n, input int gap);
    for (int b = 0; b < n; b++) begin
      int t;
      t = 0;
      rx_data[i]  = bytes[8*b +: 8];
      rx_valid[i] = 1'b1;
      while (!rx_ready[i] && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!rx_ready[i]) check_eq("rx_ready_wait", 32'(rx_ready[i]), 1);
      @(negedge clk);
      rx_valid[i] = 1'b0;
      if (b != n - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic recv_byte(input int i, input int exp, input string tag, input int stall);
    int         t;
    int         bad;
    logic [7:0] d0;
    logic [2:0] a0;
    t   = 0;
    bad = 0;
    while (!tx_valid[i] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!tx_valid[i]) check_eq({tag, "_valid_wait"}, 32'(tx_valid[i]), 1);
    d0 = tx_data[i];
    a0 = Addr_emu[i];
    for (int n = 0; n < stall; n++) begin
      @(negedge clk);
      if (tx_data[i] !== d0 || tx_valid[i] !== 1'b1 || Addr_emu[i] !== a0) bad++;
    end
    if (stall > 0) check_eq({tag, "_stall_hold"}, bad, 0);
    check_eq(tag, 32'(tx_data[i]), exp);
    tx_ready[i] = 1'b1;
    @(negedge clk);
    tx_ready[i] = 1'b0;
  endtask

  task automatic run_frame(input int i, input logic [23:0] bytes, input int gap,
                           input int stall);
    int hs0;
    hs0 = mon[i].hs_cnt;
    send_bytes(i, bytes, 3, gap);
    recv_byte(i, 'hA7, "tx_byte0", stall);
    recv_byte(i, 'h01, "tx_byte1", stall);
`ifdef EMU_FRAME_CNT_EN
    recv_byte(i, fexp[i], "tx_trailer", stall);
    fexp[i] = fexp[i] + 1;
`endif
    check_eq("rx_ready_after", 32'(rx_ready[i]), 1);
    check_eq("busy_after", 32'(busy[i]), 0);
    repeat (4) @(negedge clk);
    check_eq("tx_count", mon[i].hs_cnt - hs0, NResp);
    check_eq("tx_valid_idle", 32'(tx_valid[i]), 0);
    check_eq("wrapper_stim", 32'(mon[i].stim), 32'(bytes));
    check_eq("dut_inputs", 32'(mon[i].dut_in), 32'(bytes));
  endtask

  initial begin
    int t;
    for (int i = 0; i < 3; i++) begin
      rst[i]      = 1'b1;
      rx_data[i]  = 8'h00;
      rx_valid[i] = 1'b0;
      tx_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // Reset state.
    check_eq("rst_rx_ready", 32'(rx_ready[0]), 1);
    check_eq("rst_tx_valid", 32'(tx_valid[0]), 0);
    check_eq("rst_tx_data", 32'(tx_data[0]), 0);
    check_eq("rst_addr", 32'(Addr_emu[0]), 0);
    check_eq("rst_din", 32'(Din_emu[0]), 0);
    check_eq("rst_load", 32'(load_emu[0]), 0);
    check_eq("rst_get", 32'(get_emu[0]), 0);
    check_eq("rst_clk_dut", 32'(clk_dut[0]), 0);
    check_eq("rst_busy", 32'(busy[0]), 0);

    // Back-to-back frame, host always ready.
    run_frame(0, 24'h013C5A, 0, 0);
    check_eq("t1_load_cnt", mon[0].load_cnt, 1);
    check_eq("t1_get_cnt", mon[0].get_cnt, 1);
    check_eq("t1_rise_cnt", mon[0].rise_cnt, 1);
    check_eq("t1_clk_high", mon[0].fall_cyc - mon[0].rise_cyc, 1);
    check_eq("t1_clk_low", mon[0].get_cyc - mon[0].fall_cyc, 1);
    check_eq("t1_acc_to_load", mon[0].load_cyc - mon[0].acc_cyc, 2);
    // tx_valid is set by the 7th edge after the accept edge, so it is seen at the 8th.
    check_eq("t1_acc_to_tx", mon[0].tv_prev - mon[0].acc_cyc, 8);
    check_eq("t1_tx_spacing", mon[0].tv_last - mon[0].tv_prev, 3);

    // Same frame with a slow host.
    run_frame(0, 24'h013C5A, 0, 5);
    check_eq("t2_load_cnt", mon[0].load_cnt, 2);
    check_eq("t2_acc_to_tx", mon[0].tv_prev - mon[0].acc_cyc, 8);

    // Gapped stimulus bytes.
    run_frame(0, 24'h013C5A, 3, 0);
    check_eq("t3_acc_to_load", mon[0].load_cyc - mon[0].acc_cyc, 2);
    check_eq("t3_rise_cnt", mon[0].rise_cnt, 3);

    // Reset mid-RX, then mid-CLKH, with CLK_HALF=4.
    @(negedge clk);
    send_bytes(1, 24'h000099, 1, 0);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    check_eq("t4_rx_rst_busy", 32'(busy[1]), 0);
    check_eq("t4_rx_rst_addr", 32'(Addr_emu[1]), 0);
    send_bytes(1, 24'hCCBBAA, 3, 0);
    t = 0;
    while (!clk_dut[1] && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check_eq("t4_in_clkh", 32'(clk_dut[1]), 1);
    check_eq("t4_partial_discard", 32'(mon[1].dut_in), 'hCCBBAA);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    check_eq("t4_clk_dut", 32'(clk_dut[1]), 0);
    check_eq("t4_tx_valid", 32'(tx_valid[1]), 0);
    check_eq("t4_rx_ready", 32'(rx_ready[1]), 1);
    check_eq("t4_addr", 32'(Addr_emu[1]), 0);
    run_frame(1, 24'h332211, 0, 0);
    check_eq("t4_rise_cnt", mon[1].rise_cnt, 2);
    check_eq("t4_get_cnt", mon[1].get_cnt, 1);
    check_eq("t4_clk_high", mon[1].fall_cyc - mon[1].rise_cyc, 4);

    // CLK_HALF=3 period shape.
    run_frame(2, 24'h030201, 0, 0);
    check_eq("t5_clk_high", mon[2].fall_cyc - mon[2].rise_cyc, 3);
    check_eq("t5_clk_low", mon[2].get_cyc - mon[2].fall_cyc, 3);
    check_eq("t5_rise_cnt", mon[2].rise_cnt, 1);

    for (int i = 0; i < 3; i++) check_eq("pulse_overlap", mon[i].ovl_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
